quad_step_gen: RTL and testbench



---
 rtl/quad_pkg.sv | 17 +
 rtl/quad_dwell_timer.sv | 27 ++
 rtl/quad_step_gen.sv | 114 +++++++++++
 tb/tb_quad_step_gen.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// quad_pkg: shared quadrature phase encodings, phase stepping function and step-generator states.
//   PH_*       : {A,B} phase encodings
//   quad_next  : next {A,B} phase for dir=1 (forward) or dir=0 (reverse)
//   qs_state_t : step generator FSM states
package quad_pkg;
    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_01 = 2'b01;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_10 = 2'b10;

    typedef enum logic [1:0] {QS_IDLE, QS_STEP, QS_HOLD} qs_state_t;

    // Forward walks 00->01->11->10, reverse walks the inverse; one bit flips per call.
    function automatic logic [1:0] quad_next(input logic [1:0] phase, input logic dir);
        return dir ? {phase[0], ~phase[1]} : {~phase[0], phase[1]};
    endfunction
endpackage

// File: rtl/quad_dwell_timer.sv
// quad_dwell_timer: 16-bit dwell down-counter, loads DWELL-1 and counts to 0.
//   clk, resetn : clock, async active-low reset
//   load        : reload with DWELL-1
//   expired     : counter is 0
//   expiring    : counter is 1 (expires on the next cycle)
module quad_dwell_timer #(
    parameter int DWELL = 256
) (
    input  logic clk,
    input  logic resetn,
    input  logic load,
    output logic expired,
    output logic expiring
);
    localparam logic [15:0] LOAD_VAL = 16'(DWELL - 1);

    logic [15:0] cnt_q, cnt_d;

    always_comb cnt_d = load ? LOAD_VAL : (cnt_q != 16'd0 ? cnt_q - 16'd1 : cnt_q);

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) cnt_q <= '0;
        else         cnt_q <= cnt_d;

    assign expired  = cnt_q == 16'd0;
    assign expiring = cnt_q == 16'd1;
endmodule

// File: rtl/quad_step_gen.sv
// quad_step_gen: quadrature encoder emulator emitting Gray-coded A/B edges with a minimum dwell.
//   clk, resetn          : clock, async active-low reset
//   cmd_valid/cmd_ready  : step command handshake (cmd_steps edges, cmd_dir 1=forward)
//   stop                 : abort after the phase in progress
//   quadA, quadB         : registered quadrature outputs
//   busy, done           : command in progress / one-cycle completion pulse
//   position             : wrapping count of emitted edges (+1 forward, -1 reverse)
module quad_step_gen
    import quad_pkg::*;
#(
    parameter int DWELL  = 256,
    parameter int STEP_W = 8,
    parameter int POS_W  = 10
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic              cmd_dir,
    input  logic              stop,
    output logic              quadA,
    output logic              quadB,
    output logic              busy,
    output logic              done,
    output logic [POS_W-1:0]  position
);
    qs_state_t         state_q, state_d;
    logic [STEP_W-1:0] rem_q, rem_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic [1:0]        phase_q, phase_d;
    logic              dir_q, dir_d, stop_q, stop_d, done_q, done_d;
    logic              t_load, t_expired, t_expiring;

    quad_dwell_timer #(.DWELL(DWELL)) u_timer (
        .clk      (clk),
        .resetn   (resetn),
        .load     (t_load),
        .expired  (t_expired),
        .expiring (t_expiring)
    );

    // The STEP cycle is the last cycle of the previous dwell, so a continuing
    // command leaves HOLD one cycle before expiry; a finishing one waits for expiry.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        pos_d   = pos_q;
        phase_d = phase_q;
        dir_d   = dir_q;
        stop_d  = stop_q;
        done_d  = 1'b0;
        t_load  = 1'b0;
        case (state_q)
            QS_IDLE: begin
                stop_d = 1'b0;
                if (cmd_valid) begin
                    if (cmd_steps != '0) begin
                        state_d = QS_STEP;
                        rem_d   = cmd_steps;
                        dir_d   = cmd_dir;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            QS_STEP: begin
                phase_d = quad_next(phase_q, dir_q);
                pos_d   = pos_q + (dir_q ? POS_W'(1) : {POS_W{1'b1}});
                rem_d   = rem_q - STEP_W'(1);
                stop_d  = stop_q | stop;
                t_load  = 1'b1;
                state_d = QS_HOLD;
            end
            QS_HOLD: begin
                stop_d = stop_q | stop;
                if (t_expiring && rem_q != '0 && !(stop_q | stop)) begin
                    state_d = QS_STEP;
                end else if (t_expired) begin
                    state_d = QS_IDLE;
                    done_d  = 1'b1;
                    stop_d  = 1'b0;
                end
            end
            default: state_d = QS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            state_q <= QS_IDLE;
            rem_q   <= '0;
            pos_q   <= '0;
            phase_q <= PH_00;
            dir_q   <= 1'b0;
            stop_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            pos_q   <= pos_d;
            phase_q <= phase_d;
            dir_q   <= dir_d;
            stop_q  <= stop_d;
            done_q  <= done_d;
        end

    assign cmd_ready = state_q == QS_IDLE;
    assign busy      = !cmd_ready;
    assign done      = done_q;
    assign position  = pos_q;
    assign quadA     = phase_q[1];
    assign quadB     = phase_q[0];
endmodule

// File: tb/tb_quad_step_gen.sv
// tb_quad_step_gen: directed and randomized commands checked against a timeline model of edge times and positions.
module tb_quad_step_gen;
    localparam int D = 4;

    logic       clk = 1'b0, resetn = 1'b0, cmd_valid = 1'b0, cmd_dir = 1'b0, stop = 1'b0;
    logic [7:0] cmd_steps = 8'd0;
    logic       cmd_ready, quadA, quadB, busy, done;
    logic [9:0] position;

    int         n_chk = 0, n_fail = 0, cyc = 0, last_tr = -100;
    logic [1:0] last_ab = 2'b00;
    logic [9:0] model_pos = 10'd0;
    logic [1:0] gray [4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    quad_step_gen #(.DWELL(D), .STEP_W(8), .POS_W(10)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_steps (cmd_steps),
        .cmd_dir   (cmd_dir),
        .stop      (stop),
        .quadA     (quadA),
        .quadB     (quadB),
        .busy      (busy),
        .done      (done),
        .position  (position)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected behaviour from the command timeline: edge n lands D cycles after edge n-1,
    // the first one cycle after accept; done/ready come D cycles after the last edge.
    // {A,B} is always the Gray code of the position modulo 4.
    task automatic run_cmd(input int n, input bit d, input int s_edge, input bit hold, input int rst_m);
        int         e, last, stop_m, guard, edges;
        logic [9:0] p0, pexp;
        logic [1:0] ab;
        guard = 0;
        while (!cmd_ready && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("ready_wait", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_steps = 8'(n);
        cmd_dir   = d;
        p0        = model_pos;
        pexp      = p0;
        e         = (s_edge > 0 && s_edge < n) ? s_edge : n;
        last      = (e == 0) ? 0 : 1 + e * D;
        stop_m    = (s_edge > 0) ? 1 + (s_edge - 1) * D + int'($urandom_range(0, D - 2)) : -1;
        for (int m = 0; m <= last; m++) begin
            @(posedge clk);
            #1;
            if (m == 0 && !hold) cmd_valid = 1'b0;
            stop  = (m == stop_m);
            edges = (m == 0) ? 0 : (((m - 1) / D + 1 < e) ? (m - 1) / D + 1 : e);
            pexp  = d ? p0 + 10'(edges) : p0 - 10'(edges);
            ab    = {quadA, quadB};
            chk("position", 32'(position), 32'(pexp));
            chk("quadAB", 32'(ab), 32'(gray[pexp[1:0]]));
            chk("done", 32'(done), 32'(m == last));
            chk("cmd_ready", 32'(cmd_ready), 32'(m == last));
            chk("busy", 32'(busy), 32'(m != last));
            if (ab != last_ab) begin
                chk("spacing", 32'(cyc - last_tr >= D), 32'd1);
                last_tr = cyc;
                last_ab = ab;
            end
            if (m < last) begin
                cmd_steps = 8'($urandom);
                cmd_dir   = 1'($urandom);
            end
            if (m == rst_m) begin
                resetn    = 1'b0;
                cmd_valid = 1'b0;
                stop      = 1'b0;
                #1;
                chk("rst_quadAB", 32'({quadA, quadB}), 32'd0);
                chk("rst_position", 32'(position), 32'd0);
                model_pos = 10'd0;
                last_ab   = 2'b00;
                last_tr   = cyc - 100;
                return;
            end
        end
        stop      = 1'b0;
        model_pos = pexp;
    endtask

    initial begin
        int n, s;
        bit d, h;
        gray = '{2'b00, 2'b01, 2'b11, 2'b10};
        repeat (2) @(posedge clk);
        #1;
        chk("reset_quadAB", 32'({quadA, quadB}), 32'd0);
        chk("reset_position", 32'(position), 32'd0);
        chk("reset_ready", 32'(cmd_ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        @(negedge clk) resetn = 1'b1;
        @(posedge clk);
        #1;
        run_cmd(4, 1'b1, 0, 1'b0, -1);
        run_cmd(4, 1'b0, 0, 1'b0, -1);
        run_cmd(3, 1'b0, 0, 1'b0, -1);
        run_cmd(0, 1'b1, 0, 1'b0, -1);
        run_cmd(3, 1'b1, 0, 1'b0, -1);
        run_cmd(200, 1'b1, 3, 1'b0, -1);
        run_cmd(3, 1'b1, 0, 1'b1, -1);
        run_cmd(2, 1'b0, 0, 1'b1, -1);
        run_cmd(0, 1'b0, 0, 1'b1, -1);
        run_cmd(5, 1'b1, 0, 1'b0, -1);
        for (int i = 0; i < 10; i++) begin
            n = int'($urandom_range(0, 12));
            d = 1'($urandom);
            s = (n > 1 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, n - 1)) : 0;
            h = (i < 9) ? 1'($urandom) : 1'b0;
            run_cmd(n, d, s, h, -1);
        end
        run_cmd(6, 1'b1, 0, 1'b0, 2 + D);
        #2;
        @(negedge clk) resetn = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ready", 32'(cmd_ready), 32'd1);
        chk("post_rst_done", 32'(done), 32'd0);
        chk("post_rst_position", 32'(position), 32'd0);
        run_cmd(2, 1'b0, 0, 1'b0, -1);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
